// File: rtl/uart_loader.sv
// uart_loader: receives a framed image over the UART byte stream and writes it
// word-by-word into instruction memory while holding the CPU in reset.
//
// Frame: SYNC_BYTE, LEN (LEN_BYTES bytes, LSB first, word count N),
//        N*BPW data bytes (each word LSB first), CSUM (8-bit sum of LEN+data).
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   data, data_tick received byte and its one-cycle strobe
//   mem_wen/addr/wdata  one-cycle memory write port
//   rst_out         CPU hold-in-reset (held after errors until a good frame)
//   busy            a frame is in progress
//   done            one-cycle pulse on a frame completing with good checksum
//   err             sticky error (bad length, bad checksum, inter-byte timeout)
//   words_written   words written by the current or last frame
module uart_loader #(
  parameter int         ADDR_WIDTH     = 14,
  parameter int         DATA_WIDTH     = 32,
  parameter int         LEN_BYTES      = 2,
  parameter logic [7:0] SYNC_BYTE      = 8'hA5,
  parameter int         TIMEOUT_CYCLES = 50000000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [7:0]            data,
  input  logic                  data_tick,
  output logic                  mem_wen,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  rst_out,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [ADDR_WIDTH:0]   words_written
);

  localparam int BPW = DATA_WIDTH / 8;
  localparam int LW  = 8 * LEN_BYTES;
  localparam int CW  = LW + ADDR_WIDTH + 2;
  localparam int TW  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  localparam logic [TW-1:0]     TMO_LAST  = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [7:0]        LEN_LAST  = 8'(LEN_BYTES - 1);
  localparam logic [7:0]        WORD_LAST = 8'(BPW - 1);
  localparam logic [ADDR_WIDTH:0] WW_ONE  = (ADDR_WIDTH+1)'(1);

  typedef enum logic [1:0] {ST_IDLE, ST_LEN, ST_DATA, ST_CSUM} state_t;

  state_t                state_q, state_d;
  logic [7:0]            byte_cnt;
  logic [7:0]            sum;
  logic [TW-1:0]         tmo_cnt;
  logic [ADDR_WIDTH:0]   n_words;
  logic [LW-1:0]         len_shift;
  logic [DATA_WIDTH-1:0] word_buf;

  logic [LW-1:0]         len_next;
  logic [DATA_WIDTH-1:0] word_next;
  logic                  len_over, len_zero, len_last, word_last, frame_last, timeout;

  // Bytes arrive LSB first, so each new byte enters at the top and the
  // register shifts right; after the last byte everything sits in place.
  assign len_next   = (len_shift >> 8) | (LW'(data) << (LW - 8));
  assign word_next  = (word_buf >> 8) | (DATA_WIDTH'(data) << (DATA_WIDTH - 8));
  assign len_over   = CW'(len_next) > (CW'(1) << ADDR_WIDTH);
  assign len_zero   = (len_next == '0);
  assign len_last   = (byte_cnt == LEN_LAST);
  assign word_last  = (byte_cnt == WORD_LAST);
  // words_written already counts every earlier word of this frame when the
  // last byte of the next word arrives, so this marks the final word.
  assign frame_last = ((words_written + WW_ONE) == n_words);
  assign timeout    = (state_q != ST_IDLE) && !data_tick && (tmo_cnt == TMO_LAST);

  always_comb begin
    state_d = state_q;
    if (timeout) begin
      state_d = ST_IDLE;
    end else if (data_tick) begin
      case (state_q)
        ST_IDLE: if (data == SYNC_BYTE) state_d = ST_LEN;
        ST_LEN: begin
          if (len_last) begin
            if (len_over)      state_d = ST_IDLE;
            else if (len_zero) state_d = ST_CSUM;
            else               state_d = ST_DATA;
          end
        end
        ST_DATA: if (word_last && frame_last) state_d = ST_CSUM;
        ST_CSUM: state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      byte_cnt      <= '0;
      sum           <= '0;
      tmo_cnt       <= '0;
      n_words       <= '0;
      mem_wen       <= 1'b0;
      mem_addr      <= '0;
      mem_wdata     <= '0;
      rst_out       <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      err           <= 1'b0;
      words_written <= '0;
    end else begin
      state_q <= state_d;
      mem_wen <= 1'b0;
      done    <= 1'b0;

      if (state_q == ST_IDLE || data_tick || timeout) tmo_cnt <= '0;
      else                                            tmo_cnt <= tmo_cnt + TW'(1);

      if (timeout) begin
        err  <= 1'b1;
        busy <= 1'b0;
      end else if (data_tick) begin
        case (state_q)
          ST_IDLE: begin
            if (data == SYNC_BYTE) begin
              rst_out       <= 1'b1;
              busy          <= 1'b1;
              err           <= 1'b0;
              words_written <= '0;
              sum           <= '0;
              byte_cnt      <= '0;
            end
          end
          ST_LEN: begin
            sum      <= sum + data;
            byte_cnt <= byte_cnt + 8'd1;
            if (len_last) begin
              byte_cnt <= '0;
              n_words  <= (ADDR_WIDTH+1)'(len_next);
              if (len_over) begin
                err  <= 1'b1;
                busy <= 1'b0;
              end
            end
          end
          ST_DATA: begin
            sum      <= sum + data;
            byte_cnt <= byte_cnt + 8'd1;
            // The write strobe is registered here and shows up on the next
            // cycle, so a byte landing in the write cycle is never lost.
            if (word_last) begin
              byte_cnt      <= '0;
              mem_wen       <= 1'b1;
              mem_addr      <= words_written[ADDR_WIDTH-1:0];
              mem_wdata     <= word_next;
              words_written <= words_written + WW_ONE;
            end
          end
          ST_CSUM: begin
            busy <= 1'b0;
            if (data == sum) begin
              done    <= 1'b1;
              rst_out <= 1'b0;
            end else begin
              err <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  // Assembly registers need no reset: they are fully overwritten before use.
  always_ff @(posedge clk) begin
    if (data_tick && state_q == ST_LEN)  len_shift <= len_next;
    if (data_tick && state_q == ST_DATA) word_buf  <= word_next;
  end

endmodule

// File: tb/tb_uart_loader.sv
module tb_uart_loader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [7:0] din [2];
  logic       tk  [2];

  logic        wen0, rsto0, busy0, done0, err0;
  logic [3:0]  addr0;
  logic [31:0] wd0;
  logic [4:0]  ww0;

  logic        wen1, rsto1, busy1, done1, err1;
  logic [3:0]  addr1;
  logic [15:0] wd1;
  logic [4:0]  ww1;

  uart_loader #(.ADDR_WIDTH(4), .DATA_WIDTH(32), .LEN_BYTES(2), .SYNC_BYTE(8'hA5),
                .TIMEOUT_CYCLES(100)) u_a (
    .clk(clk), .rst(rst), .data(din[0]), .data_tick(tk[0]),
    .mem_wen(wen0), .mem_addr(addr0), .mem_wdata(wd0), .rst_out(rsto0),
    .busy(busy0), .done(done0), .err(err0), .words_written(ww0));

  uart_loader #(.ADDR_WIDTH(4), .DATA_WIDTH(16), .LEN_BYTES(2), .SYNC_BYTE(8'hA5),
                .TIMEOUT_CYCLES(100)) u_b (
    .clk(clk), .rst(rst), .data(din[1]), .data_tick(tk[1]),
    .mem_wen(wen1), .mem_addr(addr1), .mem_wdata(wd1), .rst_out(rsto1),
    .busy(busy1), .done(done1), .err(err1), .words_written(ww1));

  int checks = 0;
  int errors = 0;

  // Scoreboard: expected writes {addr, data} and outstanding done pulses.
  logic [35:0] expw0[$];
  logic [35:0] expw1[$];
  int          exp_done [2];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitors
  always @(negedge clk) begin
    logic [35:0] e;
    if (wen0 === 1'b1) begin
      checks++;
      if (expw0.size() == 0) begin
        errors++;
        $display("FAIL a_unexpected_write: got addr %0h data %0h expected no write", addr0, wd0);
      end else begin
        e = expw0.pop_front();
        if ({addr0, wd0} !== e) begin
          errors++;
          $display("FAIL a_write: got %0h expected %0h", {addr0, wd0}, e);
        end
      end
    end
    if (done0 === 1'b1) begin
      checks++;
      if (exp_done[0] == 0) begin
        errors++;
        $display("FAIL a_unexpected_done: got 1 expected 0");
      end else exp_done[0]--;
    end
  end

  always @(negedge clk) begin
    logic [35:0] e;
    if (wen1 === 1'b1) begin
      checks++;
      if (expw1.size() == 0) begin
        errors++;
        $display("FAIL b_unexpected_write: got addr %0h data %0h expected no write", addr1, wd1);
      end else begin
        e = expw1.pop_front();
        if ({addr1, 16'h0000, wd1} !== e) begin
          errors++;
          $display("FAIL b_write: got %0h expected %0h", {addr1, 16'h0000, wd1}, e);
        end
      end
    end
    if (done1 === 1'b1) begin
      checks++;
      if (exp_done[1] == 0) begin
        errors++;
        $display("FAIL b_unexpected_done: got 1 expected 0");
      end else exp_done[1]--;
    end
  end

  task automatic send_byte(input int w, input logic [7:0] b, input int gap);
    repeat (gap) begin @(posedge clk); #1; end
    din[w] = b;
    tk[w]  = 1'b1;
    @(posedge clk); #1;
    tk[w]  = 1'b0;
  endtask

  task automatic chk_status(input int w, input string tag, input logic e_err,
                            input logic e_rst, input logic e_busy, input int e_ww);
    if (w == 0) begin
      check({tag, "_err"},    err0,  e_err);
      check({tag, "_rstout"}, rsto0, e_rst);
      check({tag, "_busy"},   busy0, e_busy);
      check({tag, "_words"},  ww0,   64'(e_ww));
    end else begin
      check({tag, "_err"},    err1,  e_err);
      check({tag, "_rstout"}, rsto1, e_rst);
      check({tag, "_busy"},   busy1, e_busy);
      check({tag, "_words"},  ww1,   64'(e_ww));
    end
  endtask

  task automatic chk_drained(input int w, input string tag);
    check({tag, "_pending_writes"}, (w == 0) ? expw0.size() : expw1.size(), 0);
    check({tag, "_pending_done"},   exp_done[w], 0);
  endtask

  // Reference model: builds the byte stream from the frame rules and records
  // the writes and done pulse the loader must produce.
  task automatic send_frame(input int w, input int n, input bit bad,
                            input logic [31:0] fixed[$], input int maxgap, input string tag);
    logic [7:0]  sum;
    logic [15:0] nl;
    logic [31:0] wv;
    int          bpw;
    bpw = (w == 0) ? 4 : 2;
    nl  = 16'(n);
    sum = 8'h00;
    send_byte(w, 8'hA5, $urandom_range(maxgap, 0));
    send_byte(w, nl[7:0], $urandom_range(maxgap, 0));
    sum += nl[7:0];
    send_byte(w, nl[15:8], $urandom_range(maxgap, 0));
    sum += nl[15:8];
    chk_status(w, {tag, "_mid"}, 1'b0, 1'b1, 1'b1, 0);
    for (int i = 0; i < n; i++) begin
      wv = (fixed.size() > i) ? fixed[i] : $urandom;
      if (bpw == 2) wv[31:16] = 16'h0000;
      if (w == 0) expw0.push_back({4'(i), wv});
      else        expw1.push_back({4'(i), wv});
      for (int k = 0; k < bpw; k++) begin
        sum += wv[8*k +: 8];
        send_byte(w, wv[8*k +: 8], $urandom_range(maxgap, 0));
      end
    end
    if (!bad) exp_done[w]++;
    send_byte(w, bad ? sum + 8'd1 : sum, $urandom_range(maxgap, 0));
    repeat (3) @(posedge clk);
    #1;
    chk_status(w, tag, bad, bad, 1'b0, n);
    chk_drained(w, tag);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] fx[$];
    exp_done[0] = 0;
    exp_done[1] = 0;

    // Reset with ticks active
    rst = 1'b1;
    din[0] = 8'hA5; din[1] = 8'hA5;
    tk[0] = 1'b1;   tk[1] = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk_status(0, "reset_a", 1'b0, 1'b0, 1'b0, 0);
    chk_status(1, "reset_b", 1'b0, 1'b0, 1'b0, 0);
    check("reset_a_wen", wen0, 1'b0);
    check("reset_a_done", done0, 1'b0);
    check("reset_a_addr", addr0, 0);
    check("reset_a_wdata", wd0, 0);
    check("reset_b_wen", wen1, 1'b0);
    rst = 1'b0;
    tk[0] = 1'b0; tk[1] = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Directed default frame, bad checksum, then good again
    fx = '{32'h12345678, 32'hDEADBEEF};
    send_frame(0, 2, 1'b0, fx, 0, "frame2");
    send_frame(0, 2, 1'b1, fx, 0, "frame2_badcsum");
    send_frame(0, 2, 1'b0, fx, 0, "frame2_recover");

    // Zero-length frame
    fx = {};
    send_frame(0, 0, 1'b0, fx, 0, "len0");

    // Length one beyond capacity
    send_byte(0, 8'hA5, 0);
    send_byte(0, 8'h11, 0);
    send_byte(0, 8'h00, 0);
    repeat (2) @(posedge clk);
    #1;
    chk_status(0, "len_over", 1'b1, 1'b1, 1'b0, 0);

    // Exactly full memory
    send_frame(0, 16, 1'b0, fx, 0, "len16");

    // Inter-byte timeout boundary
    send_byte(0, 8'hA5, 0);
    send_byte(0, 8'h01, 0);
    send_byte(0, 8'h00, 0);
    send_byte(0, 8'h12, 0);
    repeat (99) @(posedge clk);
    #1;
    chk_status(0, "tmo_before", 1'b0, 1'b1, 1'b1, 0);
    @(posedge clk); #1;
    chk_status(0, "tmo_fired", 1'b1, 1'b1, 1'b0, 0);
    send_byte(0, 8'h01, 0);
    send_byte(0, 8'h00, 0);
    send_byte(0, 8'h34, 0);
    repeat (2) @(posedge clk);
    #1;
    chk_status(0, "tmo_ignore", 1'b1, 1'b1, 1'b0, 0);
    send_frame(0, 1, 1'b0, fx, 1, "tmo_recover");

    // Reset after 3 data bytes
    send_byte(0, 8'hA5, 0);
    send_byte(0, 8'h02, 0);
    send_byte(0, 8'h00, 0);
    send_byte(0, 8'h11, 0);
    send_byte(0, 8'h22, 0);
    send_byte(0, 8'h33, 0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk_status(0, "rst_mid", 1'b0, 1'b0, 1'b0, 0);

    // Reset coinciding with the byte that completes a word
    send_byte(0, 8'hA5, 0);
    send_byte(0, 8'h02, 0);
    send_byte(0, 8'h00, 0);
    send_byte(0, 8'h11, 0);
    send_byte(0, 8'h22, 0);
    send_byte(0, 8'h33, 0);
    din[0] = 8'h44; tk[0] = 1'b1; rst = 1'b1;
    @(posedge clk); #1;
    tk[0] = 1'b0; rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_status(0, "rst_pending", 1'b0, 1'b0, 1'b0, 0);
    send_frame(0, 3, 1'b0, fx, 0, "after_rst");

    // 16-bit word instance
    fx = '{32'h0000ABCD};
    send_frame(1, 1, 1'b0, fx, 0, "w16");
    fx = {};

    // Randomized frames
    for (int r = 0; r < 14; r++)
      send_frame(0, $urandom_range(16, 0), ($urandom_range(3, 0) == 0), fx, 2, "rand_a");
    for (int r = 0; r < 8; r++)
      send_frame(1, $urandom_range(16, 0), ($urandom_range(3, 0) == 0), fx, 2, "rand_b");

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
